// File: rtl/cpu_pkg.sv
// Shared CPU-side types and widths for the bus interface unit and its environment.
package cpu_pkg;

    localparam int CPU_AW = 20;
    localparam int CPU_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } biu_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_biu_if.sv
// Signal bundle between the fetch/data masters, the BIU and the external memory bus.
interface mem_biu_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic              if_req;
    logic [AW-1:0]     if_adr;
    logic              if_ack;
    logic [DW-1:0]     if_dtr;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_adr;
    logic [DW/8-1:0]   d_be;
    logic [DW-1:0]     d_wdat;
    logic [DW-1:0]     d_rdat;
    logic              d_ack;
    logic              d_err;

    logic              m_cyc;
    logic              m_we;
    logic [AW-1:0]     m_adr;
    logic [DW/8-1:0]   m_be;
    logic [DW-1:0]     m_wdat;
    logic [DW-1:0]     m_rdat;
    logic              m_rdy;

    // BIU view of the bundle
    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_be, d_wdat, m_rdat, m_rdy,
        output if_ack, if_dtr, if_err, d_rdat, d_ack, d_err,
        output m_cyc, m_we, m_adr, m_be, m_wdat
    );

    // Environment view: CPU masters plus the memory slave
    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_be, d_wdat, m_rdat, m_rdy,
        input  if_ack, if_dtr, if_err, d_rdat, d_ack, d_err,
        input  m_cyc, m_we, m_adr, m_be, m_wdat
    );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags a bus cycle stalled for TMO cycles.
module bus_watchdog #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW  = $clog2(TMO + 1);
    localparam logic [CW-1:0] LIM = CW'(TMO);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && (cnt_q != LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIM);

endmodule

// File: rtl/mem_biu.sv
// Bus interface unit: arbitrates fetch and data masters onto one 16-bit memory bus
// transaction at a time, with wait states and a watchdog for hung cycles.
module mem_biu
    import cpu_pkg::*;
#(
    parameter int AW  = CPU_AW,
    parameter int DW  = CPU_DW,
    parameter int TMO = 15
) (
    input  logic       clk,
    input  logic       rst,
    mem_biu_if.slave   bus
);

    localparam int BW = DW / 8;

    biu_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_q, last_d;
    logic            m_cyc_q, m_cyc_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_adr_q, m_adr_d;
    logic [BW-1:0]   m_be_q, m_be_d;
    logic [DW-1:0]   m_wdat_q, m_wdat_d;
    logic            if_ack_q, if_ack_d;
    logic            if_err_q, if_err_d;
    logic [DW-1:0]   if_dtr_q, if_dtr_d;
    logic            d_ack_q, d_ack_d;
    logic            d_err_q, d_err_d;
    logic [DW-1:0]   d_rdat_q, d_rdat_d;
    logic            wd_clr_s, wd_en_s, wd_expired_s;

    bus_watchdog #(.TMO(TMO)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        m_cyc_d  = m_cyc_q;
        m_we_d   = m_we_q;
        m_adr_d  = m_adr_q;
        m_be_d   = m_be_q;
        m_wdat_d = m_wdat_q;
        if_ack_d = 1'b0;
        if_err_d = 1'b0;
        if_dtr_d = if_dtr_q;
        d_ack_d  = 1'b0;
        d_err_d  = 1'b0;
        d_rdat_d = d_rdat_q;
        wd_clr_s = 1'b0;
        wd_en_s  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the master that lost the previous grant goes first
                if (bus.if_req && (!bus.d_req || (last_q == OWN_D))) begin
                    state_d  = BUS;
                    owner_d  = OWN_IF;
                    last_d   = OWN_IF;
                    m_cyc_d  = 1'b1;
                    m_adr_d  = bus.if_adr;
                    m_we_d   = 1'b0;
                    m_be_d   = {BW{1'b1}};
                    m_wdat_d = {DW{1'b0}};
                    wd_clr_s = 1'b1;
                end else if (bus.d_req) begin
                    state_d  = BUS;
                    owner_d  = OWN_D;
                    last_d   = OWN_D;
                    m_cyc_d  = 1'b1;
                    m_adr_d  = bus.d_adr;
                    m_we_d   = bus.d_we;
                    m_be_d   = bus.d_be;
                    m_wdat_d = bus.d_wdat;
                    wd_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Slave ready takes priority over a simultaneous watchdog expiry
                if (bus.m_rdy) begin
                    state_d = ACK;
                    m_cyc_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d = 1'b1;
                        if_dtr_d = bus.m_rdat;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdat_d = bus.m_rdat;
                        end else begin
                            d_rdat_d = d_rdat_q;
                        end
                    end
                end else if (wd_expired_s) begin
                    state_d = ACK;
                    m_cyc_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                        if_dtr_d = {DW{1'b0}};
                    end else begin
                        d_ack_d  = 1'b1;
                        d_err_d  = 1'b1;
                        d_rdat_d = {DW{1'b0}};
                    end
                end else begin
                    wd_en_s = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_cyc_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            last_q   <= OWN_D;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_adr_q  <= {AW{1'b0}};
            m_be_q   <= {BW{1'b0}};
            m_wdat_q <= {DW{1'b0}};
            if_ack_q <= 1'b0;
            if_err_q <= 1'b0;
            if_dtr_q <= {DW{1'b0}};
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            d_rdat_q <= {DW{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            m_cyc_q  <= m_cyc_d;
            m_we_q   <= m_we_d;
            m_adr_q  <= m_adr_d;
            m_be_q   <= m_be_d;
            m_wdat_q <= m_wdat_d;
            if_ack_q <= if_ack_d;
            if_err_q <= if_err_d;
            if_dtr_q <= if_dtr_d;
            d_ack_q  <= d_ack_d;
            d_err_q  <= d_err_d;
            d_rdat_q <= d_rdat_d;
        end
    end

    assign bus.m_cyc  = m_cyc_q;
    assign bus.m_we   = m_we_q;
    assign bus.m_adr  = m_adr_q;
    assign bus.m_be   = m_be_q;
    assign bus.m_wdat = m_wdat_q;
    assign bus.if_ack = if_ack_q;
    assign bus.if_err = if_err_q;
    assign bus.if_dtr = if_dtr_q;
    assign bus.d_ack  = d_ack_q;
    assign bus.d_err  = d_err_q;
    assign bus.d_rdat = d_rdat_q;

endmodule
